// File: rtl/bmi_pkg.sv
// Shared types and constants for the BMI calculator: FSM states, category
// bit positions, classification thresholds, datapath widths and the
// classification helper used by the top level.
package bmi_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One-hot category bit positions; bits 6:4 are never set
    localparam int CAT_UNDER  = 0;
    localparam int CAT_NORMAL = 1;
    localparam int CAT_OVER   = 2;
    localparam int CAT_OBESE  = 3;
    localparam int CAT_ERROR  = 7;

    // Lower bounds (BMI x10) of the normal, overweight and obese bands
    localparam int unsigned THR_NORMAL = 185;
    localparam int unsigned THR_OVER   = 250;
    localparam int unsigned THR_OBESE  = 300;

    // weight * SCALE / height^2 yields BMI x10 with height in cm
    localparam int unsigned SCALE    = 100000;
    // One restoring step per quotient bit
    localparam int          DIV_ITER = 25;

    // Datapath widths
    localparam int NUM_W = 25;
    localparam int DEN_W = 16;
    localparam int BMI_W = 16;
    localparam int CAT_W = 8;

    // Map a (saturated) BMI x10 value to the one-hot category vector
    function automatic logic [CAT_W-1:0] classify(input logic [BMI_W-1:0] b,
                                                  input logic            err);
        logic [CAT_W-1:0] c;
        c = '0;
        if (err)
            c[CAT_ERROR] = 1'b1;
        else if (b < BMI_W'(THR_NORMAL))
            c[CAT_UNDER] = 1'b1;
        else if (b < BMI_W'(THR_OVER))
            c[CAT_NORMAL] = 1'b1;
        else if (b < BMI_W'(THR_OBESE))
            c[CAT_OVER] = 1'b1;
        else
            c[CAT_OBESE] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/bmi_divider.sv
// Sequential restoring divider: N-bit dividend by D-bit divisor, one
// quotient bit per cycle MSB first, N cycles after the start edge.
// A zero divisor is flagged and yields a zero quotient, but the divider
// still runs its full N cycles so the caller sees a constant latency.
module bmi_divider
    import bmi_pkg::*;
#(
    parameter int N = NUM_W,
    parameter int D = DEN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [D-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_done,
    output logic         o_dbz
);

    localparam int CNT_W = $clog2(N);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_dbz;
    logic [N-1:0]     r_quo;
    logic [D-1:0]     r_rem;
    logic [D-1:0]     r_divisor;

    logic [D:0]       w_trial;
    logic [D-1:0]     w_diff;
    logic             w_bit;
    logic [D-1:0]     w_rem_next;
    logic             w_last;

    // Shift the next dividend bit into the partial remainder and try a
    // subtraction; on success the difference always fits back into D bits.
    assign w_trial    = {r_rem, r_quo[N-1]};
    assign w_diff     = w_trial[D-1:0] - r_divisor;
    assign w_bit      = !r_dbz && (w_trial >= {1'b0, r_divisor});
    assign w_rem_next = w_bit ? w_diff : w_trial[D-1:0];
    assign w_last     = (r_cnt == CNT_W'(N - 1));

    // Load operands on start, then iterate one quotient bit per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_dbz     <= (i_divisor == '0);
            r_quo     <= (i_divisor == '0) ? '0 : i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (r_busy) begin
            r_quo <= {r_quo[N-2:0], w_bit};
            r_rem <= w_rem_next;
            if (w_last)
                r_busy <= 1'b0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // o_done marks the cycle whose closing edge produces the last bit
    assign o_done     = r_busy && w_last;
    assign o_quotient = r_quo;
    assign o_dbz      = r_dbz;

endmodule

// File: rtl/bmi.sv
// BMI calculator top: captures weight/height, forms weight*100000 and
// height^2, divides them with a sequential restoring divider, then
// saturates the quotient to 16 bits and classifies it. Fixed latency:
// done rises 27 clocks after the capturing edge regardless of data.
module bmi
    import bmi_pkg::*;
#(
    parameter int W_BITS = 8,
    parameter int H_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [W_BITS-1:0] weight,
    input  logic [H_BITS-1:0] height,
    output logic [CAT_W-1:0]  category,
    output logic [BMI_W-1:0]  bmi10,
    output logic              busy,
    output logic              done
);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_busy;
    logic               w_capture;
    logic               w_div_start;

    logic [W_BITS-1:0]  r_weight;
    logic [H_BITS-1:0]  r_height;
    logic [BMI_W-1:0]   r_bmi10;
    logic [CAT_W-1:0]   r_category;
    logic               r_done;

    logic [NUM_W-1:0]   w_num;
    logic [DEN_W-1:0]   w_den;
    logic [NUM_W-1:0]   w_quo;
    logic               w_div_done;
    logic               w_div_dbz;
    logic [BMI_W-1:0]   w_sat;
    logic [BMI_W-1:0]   w_bmi_final;
    logic [CAT_W-1:0]   w_cat;

    // Multiply stage: both products are formed from the captured operands
    // and loaded into the divider at the end of the MUL cycle.
    assign w_num = NUM_W'(r_weight) * NUM_W'(SCALE);
    assign w_den = DEN_W'(r_height) * DEN_W'(r_height);

    bmi_divider #(
        .N (NUM_W),
        .D (DEN_W)
    ) u_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_num),
        .i_divisor  (w_den),
        .o_quotient (w_quo),
        .o_done     (w_div_done),
        .o_dbz      (w_div_dbz)
    );

    // Quotients that do not fit in 16 bits clamp to all ones (obese);
    // a zero height reports 0 with only the error bit set.
    assign w_sat       = (|w_quo[NUM_W-1:BMI_W]) ? '1 : w_quo[BMI_W-1:0];
    assign w_bmi_final = w_div_dbz ? '0 : w_sat;
    assign w_cat       = classify(w_sat, w_div_dbz);

    // State register; reset has priority so an enable on a reset edge is dropped
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic and control strobes
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_capture    = 1'b0;
        w_div_start  = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (enable) begin
                    w_capture    = 1'b1;
                    w_state_next = MUL;
                end
            end
            MUL: begin
                w_div_start  = 1'b1;
                w_state_next = DIV;
            end
            DIV: begin
                if (w_div_done)
                    w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture and result registers; results hold until the next DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_weight   <= '0;
            r_height   <= '0;
            r_bmi10    <= '0;
            r_category <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_weight <= weight;
                r_height <= height;
            end
            if (r_state == DONE) begin
                r_bmi10    <= w_bmi_final;
                r_category <= w_cat;
                r_done     <= 1'b1;
            end
        end
    end

    assign category = r_category;
    assign bmi10    = r_bmi10;
    assign busy     = w_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_bmi.sv
// Scoreboard bench for the BMI calculator: expected results are pushed
// when a computation is started, a monitor queues every done pulse, and
// each test task pops and compares the two.
module tb_bmi;

    typedef struct {
        logic [15:0] bmi;
        logic [7:0]  cat;
        int          cyc;
    } res_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  weight = '0;
    logic [7:0]  height = '0;
    logic [7:0]  category;
    logic [15:0] bmi10;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    res_t exp_q[$];
    res_t act_q[$];

    bmi #(
        .W_BITS (8),
        .H_BITS (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .weight   (weight),
        .height   (height),
        .category (category),
        .bmi10    (bmi10),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every done pulse with the edge count it appeared at
    always @(negedge clk) begin
        res_t r;
        if (done === 1'b1) begin
            r.bmi = bmi10;
            r.cat = category;
            r.cyc = cyc;
            act_q.push_back(r);
        end
    end

    function automatic logic [15:0] model_bmi(input int w, input int h);
        longint q;
        if (h == 0) return 16'h0000;
        q = (longint'(w) * 100000) / (longint'(h) * h);
        if (q > 65535) q = 65535;
        return q[15:0];
    endfunction

    function automatic logic [7:0] model_cat(input int w, input int h);
        int b;
        if (h == 0) return 8'h80;
        b = int'(model_bmi(w, h));
        if (b < 185) return 8'h01;
        if (b < 250) return 8'h02;
        if (b < 300) return 8'h04;
        return 8'h08;
    endfunction

    // Drive a one-cycle enable; capture happens on the next edge and done
    // is expected 27 edges after that.
    task automatic start_one(input int w, input int h);
        res_t r;
        @(posedge clk); #1;
        weight = w[7:0];
        height = h[7:0];
        enable = 1'b1;
        r.bmi = model_bmi(w, h);
        r.cat = model_cat(w, h);
        r.cyc = cyc + 28;
        exp_q.push_back(r);
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k = 0;
        while (act_q.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (category !== 8'h00) begin errors++; $display("FAIL reset_category got %h want 00", category); end
        checks++; if (bmi10 !== 16'h0000) begin errors++; $display("FAIL reset_bmi10 got %h want 0000", bmi10); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        // enable on the final reset edge must be dropped
        enable = 1'b1;
        weight = 8'd70;
        height = 8'd175;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_enable_ignored busy got %b want 0", busy); end
        $display("test_reset: cat=%h bmi10=%h busy=%b done=%b", category, bmi10, busy, done);
    endtask

    task automatic test_single();
        res_t e, a;
        start_one(70, 175);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_high got %b want 1", busy); end
        wait_results(1, 60);
        checks++;
        if (act_q.size() == 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL single_timeout got %0d results want 1", act_q.size());
        end else begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            if (a.bmi !== e.bmi || a.cat !== e.cat || a.cyc !== e.cyc) begin
                errors++;
                $display("FAIL single_70_175 got bmi=%0d cat=%h cyc=%0d want bmi=%0d cat=%h cyc=%0d",
                         a.bmi, a.cat, a.cyc, e.bmi, e.cat, e.cyc);
            end
            $display("test_single: w=70 h=175 bmi10=%0d cat=%h cyc=%0d", a.bmi, a.cat, a.cyc);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low got %b want 0", busy); end
        weight = 8'd10;
        height = 8'd10;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bmi10 !== 16'd228) begin errors++; $display("FAIL single_hold_bmi got %0d want 228", bmi10); end
        checks++; if (category !== 8'h02) begin errors++; $display("FAIL single_hold_cat got %h want 02", category); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done); end
    endtask

    task automatic test_table(input string name, input int ws[], input int hs[]);
        res_t e, a;
        for (int i = 0; i < ws.size(); i++) begin
            start_one(ws[i], hs[i]);
            wait_results(1, 60);
            checks++;
            if (act_q.size() == 0 || exp_q.size() == 0) begin
                errors++; $display("FAIL %s_timeout w=%0d h=%0d got no result want 1", name, ws[i], hs[i]);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                if (a.bmi !== e.bmi) begin errors++; $display("FAIL %s_bmi w=%0d h=%0d got %0d want %0d", name, ws[i], hs[i], a.bmi, e.bmi); end
                checks++;
                if (a.cat !== e.cat) begin errors++; $display("FAIL %s_cat w=%0d h=%0d got %h want %h", name, ws[i], hs[i], a.cat, e.cat); end
                checks++;
                if (a.cyc !== e.cyc) begin errors++; $display("FAIL %s_latency w=%0d h=%0d got cyc %0d want %0d", name, ws[i], hs[i], a.cyc, e.cyc); end
                $display("%s: w=%0d h=%0d bmi10=%0d cat=%h cyc=%0d", name, ws[i], hs[i], a.bmi, a.cat, a.cyc);
            end
        end
    endtask

    task automatic test_boundary();
        test_table("boundary", '{74, 100, 120}, '{200, 200, 200});
        // literal spot checks, independent of the model
        checks++; if (bmi10 !== 16'd300 || category !== 8'h08) begin errors++; $display("FAIL boundary_obese got %0d/%h want 300/08", bmi10, category); end
    endtask

    task automatic test_classes();
        test_table("classes", '{50, 120, 0}, '{170, 170, 150});
        checks++; if (bmi10 !== 16'd0 || category !== 8'h01) begin errors++; $display("FAIL classes_zero_weight got %0d/%h want 0/01", bmi10, category); end
    endtask

    task automatic test_saturate_zero();
        test_table("extremes", '{255, 80}, '{1, 0});
        checks++; if (bmi10 !== 16'd0 || category !== 8'h80) begin errors++; $display("FAIL extremes_zero_height got %0d/%h want 0/80", bmi10, category); end
    endtask

    task automatic test_back_to_back();
        int   pw[4] = '{70, 50, 120, 74};
        int   ph[4] = '{175, 170, 170, 200};
        int   base;
        res_t e, a;
        @(posedge clk); #1;
        weight = pw[0][7:0];
        height = ph[0][7:0];
        enable = 1'b1;
        base   = cyc;
        for (int i = 0; i < 4; i++) begin
            e.bmi = model_bmi(pw[i], ph[i]);
            e.cat = model_cat(pw[i], ph[i]);
            e.cyc = base + 1 + 28 * i + 27;
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            // swap in the next operands mid-computation; the current one must not see them
            for (int i = 0; i < 3; i++)
                if (k == 1 + 28 * i + 10) begin
                    weight = pw[i + 1][7:0];
                    height = ph[i + 1][7:0];
                end
        end
        enable = 1'b0;
        wait_results(4, 80);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_q.size() == 0 || exp_q.size() == 0) begin
                errors++; $display("FAIL b2b_timeout idx=%0d got no result want 4 results", i);
            end else begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                if (a.bmi !== e.bmi || a.cat !== e.cat || a.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL b2b_%0d got bmi=%0d cat=%h cyc=%0d want bmi=%0d cat=%h cyc=%0d",
                             i, a.bmi, a.cat, a.cyc, e.bmi, e.cat, e.cyc);
                end
                $display("test_back_to_back: idx=%0d bmi10=%0d cat=%h cyc=%0d", i, a.bmi, a.cat, a.cyc);
            end
        end
        exp_q.delete();
        repeat (30) @(posedge clk);
        #1;
        checks++; if (act_q.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d extra results want 0", act_q.size()); end
        act_q.delete();
    endtask

    task automatic test_reset_abort();
        start_one(120, 170);
        // now one edge past capture; the 10th DIV cycle closes 10 edges later
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (category !== 8'h00) begin errors++; $display("FAIL abort_category got %h want 00", category); end
        checks++; if (bmi10 !== 16'h0000) begin errors++; $display("FAIL abort_bmi10 got %h want 0000", bmi10); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (act_q.size() != 0) begin errors++; $display("FAIL abort_no_done got %0d results want 0", act_q.size()); end
        act_q.delete();
        $display("test_reset_abort: aborted, outputs cleared");
        test_table("after_reset", '{70}, '{175});
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_classes();
        test_saturate_zero();
        test_back_to_back();
        test_reset_abort();
        checks++;
        if (exp_q.size() != 0 || act_q.size() != 0) begin
            errors++; $display("FAIL leftover got exp=%0d act=%0d want 0/0", exp_q.size(), act_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
